// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by both the command master and the APB memory slave.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS
  } apb_state_e;

  // Counter width able to hold 0..limit; at least one bit so a disabled
  // timer still elaborates.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared on entry to ACCESS, incremented per
// wait cycle, flags the last allowed wait cycle.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic Pclk,
  input  logic Prst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A limit of zero disables the abort path entirely.
  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);
      assign expired = (count_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: turns one valid/ready command into one APB transfer and
// reports completion, slave error or timeout as a single-cycle response.
//
// state  | meaning
// IDLE   | bus idle, cmd_ready high, response pulse lands here
// SETUP  | Pselx=1, Penable=0 for exactly one cycle
// ACCESS | Pselx=1, Penable=1, waiting on Pready or the wait timer
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic timer_clr;
  logic timer_inc;
  logic timer_expired;

  apb_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .Pclk    (Pclk),
    .Prst    (Prst),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clr     = 1'b0;
    timer_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        timer_clr = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // Pready wins over the timer on the limit cycle.
        if (Pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : Prdata;
          rsp_err_d     = Pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else if (timer_expired) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign Paddr       = paddr_q;
  assign Pwrite      = pwrite_q;
  assign Pwdata      = pwdata_q;
  assign Pselx       = psel_q;
  assign Penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
